// File: rtl/cvp_mem_bridge.sv
// CVP14 memory-side bridge: posted write buffer with read forwarding, and a req/ready/rvalid backing-memory port.
// Optional macro WB_MERGE_EN: core writes to an address already buffered overwrite that entry in place.
module cvp_mem_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] DataOut,
    output logic [DATA_W-1:0] DataIn,
    output logic              RdValid,
    output logic              Stall,
    output logic              Err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WR_ISSUE, S_RD_ISSUE, S_RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [ADDR_W-1:0] wb_addr_d [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_d [WB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  slot;
    logic              rd_only, rd_miss, rd_done, full, pop, push, merge, wr_stall;
    logic [DATA_W-1:0] head_data;
`ifdef WB_MERGE_EN
    logic              merge_hit;
    logic [PTR_W-1:0]  merge_idx;
`endif

    // Scan oldest to youngest so the youngest matching entry ends up selected.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = '0;
`ifdef WB_MERGE_EN
        merge_hit = 1'b0;
        merge_idx = '0;
`endif
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && wb_addr_q[slot] == Addr) begin
                hit      = 1'b1;
                hit_data = wb_data_q[slot];
`ifdef WB_MERGE_EN
                if (!(i == 0 && state_q == S_WR_ISSUE)) begin
                    merge_hit = 1'b1;
                    merge_idx = slot;
                end
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        data_in_d   = data_in_q;
        rd_valid_d  = 1'b0;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        rd_only = RD && !WR;
        rd_miss = rd_only && !hit;
        rd_done = (state_q == S_RD_WAIT) && mem_rvalid;
        full    = (count_q == CNT_W'(WB_DEPTH));
        pop     = (state_q == S_WR_ISSUE) && mem_ready;
`ifdef WB_MERGE_EN
        merge = WR && merge_hit;
`else
        merge = 1'b0;
`endif
        push     = WR && !merge && (!full || pop);
        wr_stall = WR && !merge && full && !pop;

        head_data = wb_data_q[head_q];
`ifdef WB_MERGE_EN
        if (merge) begin
            wb_data_d[merge_idx] = DataOut;
            // Keep the issue latch coherent when the head is overwritten as it launches.
            if (merge_idx == head_q) head_data = DataOut;
        end
`endif
        if (push) begin
            wb_addr_d[tail_q] = Addr;
            wb_data_d[tail_q] = DataOut;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (pop) head_d = head_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (rd_only && hit) begin
            data_in_d  = hit_data;
            rd_valid_d = 1'b1;
        end
        if (RD && WR) err_d = 1'b1;
        if (mem_rvalid && state_q != S_RD_WAIT) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (rd_miss) begin
                    state_d    = S_RD_ISSUE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = Addr;
                end else if (count_q != '0) begin
                    state_d     = S_WR_ISSUE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wb_addr_q[head_q];
                    mem_wdata_d = head_data;
                end
            end
            S_WR_ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    data_in_d  = mem_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            data_in_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            data_in_q   <= data_in_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Miss stall drops in the rvalid cycle itself so the core retires the read on that edge.
    assign Stall     = !Reset && (wr_stall || (rd_miss && !rd_done));
    assign DataIn    = data_in_q;
    assign RdValid   = rd_valid_q;
    assign Err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cvp_mem_bridge.sv
// Bench for cvp_mem_bridge: directed protocol scenarios, then random core traffic checked against a plain memory model.
module tb_cvp_mem_bridge;

    localparam int WB_DEPTH = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          Clk1 = 1'b0;
    logic          Reset;
    logic [AW-1:0] Addr;
    logic          RD, WR;
    logic [DW-1:0] DataOut, DataIn;
    logic          RdValid, Stall, Err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    cvp_mem_bridge #(.WB_DEPTH(WB_DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut),
        .DataIn(DataIn), .RdValid(RdValid), .Stall(Stall), .Err(Err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 Clk1 = ~Clk1;

    int errors = 0;
    int checks = 0;
    int auto_mode = 0;
    logic rd_pend = 1'b0;
    int rd_lat = 0;
    logic [AW-1:0] rd_paddr = '0;
    logic [DW-1:0] shadow  [logic [AW-1:0]];
    logic [DW-1:0] backing [logic [AW-1:0]];

`ifdef WB_MERGE_EN
    localparam int DUP_COUNT = 1;
`else
    localparam int DUP_COUNT = 2;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [DW-1:0] bk_read(input logic [AW-1:0] a);
        if (backing.exists(a)) return backing[a];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    // One clock; returns just after the falling edge with the responder updated.
    task automatic step();
        logic          preq, prdy, pwe;
        logic [AW-1:0] padr;
        logic [DW-1:0] pwd;
        preq = mem_req; prdy = mem_ready; pwe = mem_we; padr = mem_addr; pwd = mem_wdata;
        @(posedge Clk1);
        @(negedge Clk1);
        if (preq && !prdy && !Reset) begin
            chk("hold_req", 32'(mem_req), 1);
            chk("hold_we", 32'(mem_we), 32'(pwe));
            chk("hold_addr", 32'(mem_addr), 32'(padr));
            chk("hold_wdata", 32'(mem_wdata), 32'(pwd));
        end
        if (auto_mode != 0) begin
            if (preq && prdy) begin
                if (pwe) backing[padr] = pwd;
                else begin
                    rd_pend  = 1'b1;
                    rd_lat   = int'($urandom_range(0, 3));
                    rd_paddr = padr;
                end
            end
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                if (rd_lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = bk_read(rd_paddr);
                    rd_pend    = 1'b0;
                end else rd_lat--;
            end
            mem_ready = mem_req && ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic reset_pulse();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
    endtask

    task automatic wr_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        WR = 1'b1; Addr = a; DataOut = d;
        #1;
        chk(tag, 32'(Stall), 0);
        step();
        WR = 1'b0;
    endtask

    task automatic drain_manual();
        int n;
        n = 0;
        mem_ready = 1'b1;
        while (!(dut.count_q == '0 && !mem_req) && n < 40) begin
            step();
            n++;
        end
        chk("drain_count", 32'(dut.count_q), 0);
        mem_ready = 1'b0;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        WR = 1'b1; Addr = a; DataOut = d;
        #1;
        n = 0;
        while (Stall && n < 64) begin
            step();
            #1;
            n++;
        end
        if (Stall) chk("wr_stall_timeout", 32'(Stall), 0);
        step();
        WR = 1'b0;
        shadow[a] = d;
    endtask

    task automatic core_read(input logic [AW-1:0] a);
        int n;
        logic [DW-1:0] e;
        e = exp_read(a);
        RD = 1'b1; Addr = a;
        #1;
        n = 0;
        while (Stall && n < 64) begin
            step();
            #1;
            n++;
        end
        if (Stall) chk("rd_stall_timeout", 32'(Stall), 0);
        step();
        RD = 1'b0;
        chk("rnd_rdvalid", 32'(RdValid), 1);
        chk("rnd_rddata", 32'(DataIn), 32'(e));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [AW-1:0] a;
        Reset = 1'b1; RD = 1'b0; WR = 1'b0; Addr = '0; DataOut = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge Clk1);
        #1;
        chk("rst_datain", 32'(DataIn), 0);
        chk("rst_rdvalid", 32'(RdValid), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_memreq", 32'(mem_req), 0);
        chk("rst_memwe", 32'(mem_we), 0);
        chk("rst_memaddr", 32'(mem_addr), 0);
        chk("rst_memwdata", 32'(mem_wdata), 0);
        chk("rst_count", 32'(dut.count_q), 0);
        Reset = 1'b0;
        @(negedge Clk1);

        // Reset while a drain is pending with three entries buffered
        wr_cycle(16'h00A0, 16'h0A00, "t1_wr0");
        wr_cycle(16'h00A1, 16'h0A01, "t1_wr1");
        wr_cycle(16'h00A2, 16'h0A02, "t1_wr2");
        chk("t1_count3", 32'(dut.count_q), 3);
        chk("t1_req_on", 32'(mem_req), 1);
        chk("t1_head_addr", 32'(mem_addr), 32'h00A0);
        Reset = 1'b1;
        #1;
        chk("t1_count0", 32'(dut.count_q), 0);
        chk("t1_req0", 32'(mem_req), 0);
        chk("t1_stall0", 32'(Stall), 0);
        chk("t1_err0", 32'(Err), 0);
        Reset = 1'b0;
        step();

        // Write then forwarded read hit, backing memory never ready
        wr_cycle(16'h0010, 16'hBEEF, "t2_wr");
        RD = 1'b1; Addr = 16'h0010;
        #1;
        chk("t2_stall", 32'(Stall), 0);
        chk("t2_no_rdreq_a", 32'(mem_req && !mem_we), 0);
        step();
        RD = 1'b0;
        chk("t2_datain", 32'(DataIn), 32'hBEEF);
        chk("t2_rdvalid", 32'(RdValid), 1);
        chk("t2_no_rdreq_b", 32'(mem_req && !mem_we), 0);
        drain_manual();

        // Buffer full: fifth write stalls until a pop frees a slot
        for (int i = 0; i < 4; i++) wr_cycle(16'h0100 + 16'(i), 16'hC000 + 16'(i), "t3_nostall");
        chk("t3_count4", 32'(dut.count_q), 4);
        chk("t3_head", 32'(mem_addr), 32'h0100);
        WR = 1'b1; Addr = 16'h0104; DataOut = 16'hC004;
        #1;
        chk("t3_stall_a", 32'(Stall), 1);
        step();
        #1;
        chk("t3_stall_b", 32'(Stall), 1);
        mem_ready = 1'b1;
        #1;
        chk("t3_stall_pop", 32'(Stall), 0);
        step();
        mem_ready = 1'b0; WR = 1'b0;
        chk("t3_count_after", 32'(dut.count_q), 4);
        chk("t3_req_off", 32'(mem_req), 0);
        step();
        chk("t3_next_head", 32'(mem_addr), 32'h0101);
        drain_manual();

        // Read miss with slow backing memory
        RD = 1'b1; Addr = 16'h0200;
        #1;
        chk("t4_stall0", 32'(Stall), 1);
        step();
        #1;
        chk("t4_stall1", 32'(Stall), 1);
        chk("t4_req", 32'(mem_req), 1);
        chk("t4_we", 32'(mem_we), 0);
        chk("t4_addr", 32'(mem_addr), 32'h0200);
        step();
        #1;
        chk("t4_stall2", 32'(Stall), 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        chk("t4_req_off", 32'(mem_req), 0);
        for (int i = 0; i < 2; i++) begin
            chk("t4_stall_wait", 32'(Stall), 1);
            chk("t4_no_early_rv", 32'(RdValid), 0);
            step();
            #1;
        end
        mem_rvalid = 1'b1; mem_rdata = 16'h1234;
        #1;
        chk("t4_stall_rv", 32'(Stall), 0);
        chk("t4_no_rv_yet", 32'(RdValid), 0);
        step();
        mem_rvalid = 1'b0; RD = 1'b0;
        chk("t4_datain", 32'(DataIn), 32'h1234);
        chk("t4_rdvalid", 32'(RdValid), 1);
        step();
        chk("t4_rv_once", 32'(RdValid), 0);
        chk("t4_err", 32'(Err), 0);

        // Duplicate writes to one address, youngest data forwarded
        wr_cycle(16'h0040, 16'h1111, "t5_wr_a");
        wr_cycle(16'h0040, 16'h2222, "t5_wr_b");
        RD = 1'b1; Addr = 16'h0040;
        #1;
        chk("t5_stall", 32'(Stall), 0);
        step();
        RD = 1'b0;
        chk("t5_datain", 32'(DataIn), 32'h2222);
        chk("t5_rdvalid", 32'(RdValid), 1);
        chk("t5_count", 32'(dut.count_q), DUP_COUNT);
        drain_manual();

        // RD and WR together
        RD = 1'b1; WR = 1'b1; Addr = 16'h0005; DataOut = 16'h5555;
        #1;
        chk("t6_stall", 32'(Stall), 0);
        step();
        RD = 1'b0; WR = 1'b0;
        chk("t6_rdvalid", 32'(RdValid), 0);
        chk("t6_err", 32'(Err), 1);
        chk("t6_count", 32'(dut.count_q), 1);
        drain_manual();
        step();
        chk("t6_err_held", 32'(Err), 1);
        reset_pulse();
        chk("t6_err_clr", 32'(Err), 0);
        step();

        // Stray rvalid while idle
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("t7_err", 32'(Err), 1);
        reset_pulse();
        chk("t7_err_clr", 32'(Err), 0);
        step();

        // Random traffic against a flat memory model
        shadow.delete();
        backing.delete();
        rd_pend = 1'b0;
        auto_mode = 1;
        for (int k = 0; k < 250; k++) begin
            a = 16'h0300 + 16'($urandom_range(0, 7));
            n = int'($urandom_range(0, 9));
            if (n < 4) core_write(a, 16'($urandom));
            else if (n < 8) core_read(a);
            else step();
        end
        n = 0;
        while (!(dut.count_q == '0 && !mem_req && !rd_pend) && n < 200) begin
            step();
            n++;
        end
        chk("rnd_drained", 32'(dut.count_q), 0);
        chk("rnd_err", 32'(Err), 0);
        for (int i = 0; i < 8; i++) begin
            a = 16'h0300 + 16'(i);
            if (shadow.exists(a)) chk("rnd_final_mem", 32'(bk_read(a)), 32'(shadow[a]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
